// File: rtl/lfsr_pkg.sv
// lfsr_pkg: types and helpers shared by the XNOR LFSR generator and checker.
//   lfsr_chk_state_t : checker FSM state encoding (HUNT=0, VERIFY=1, LOCKED=2)
//   lfsr_tap_mask    : mask contribution of one 1-based tap field
//   lfsr_next        : next XNOR LFSR state word for a given width
// Helpers work on a maximum-width word; callers zero-extend their operands and
// truncate the result back to their own WIDTH.
package lfsr_pkg;

  localparam int unsigned LfsrMaxWidth = 168;

  typedef logic [LfsrMaxWidth-1:0] lfsr_word_t;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lfsr_chk_state_t;

  // Mask bits contributed by one tap field. Callers OR this over all fields.
  // Zero selects nothing; positions beyond the LFSR width are ignored.
  function automatic lfsr_word_t lfsr_tap_mask(input lfsr_word_t  tap,
                                               input int unsigned width);
    lfsr_word_t m;
    m = '0;
    if ((tap != '0) && (tap <= lfsr_word_t'(width))) begin
      m = lfsr_word_t'(1) << (tap - lfsr_word_t'(1));
    end
    return m;
  endfunction

  // Shift left, insert XNOR of the tapped bits at bit 0, keep the low width bits.
  function automatic lfsr_word_t lfsr_next(input lfsr_word_t  prev,
                                           input lfsr_word_t  mask,
                                           input int unsigned width);
    lfsr_word_t keep;
    logic       fb;
    // For width == LfsrMaxWidth the shift yields zero, so keep becomes all-ones.
    keep = (lfsr_word_t'(1) << width) - lfsr_word_t'(1);
    fb   = ~^(prev & mask);
    return ((prev << 1) | lfsr_word_t'(fb)) & keep;
  endfunction

endpackage

// File: rtl/lfsr_predict.sv
// lfsr_predict: combinational next-word predictor for the XNOR LFSR.
// Shared by generator and checker so both ends agree bit-for-bit.
//   i_taps : TAP_COUNT fields of WIDTH bits, 1-based tap positions, 0 = unused
//   i_prev : current LFSR state word
//   o_next : predicted next LFSR state word
module lfsr_predict
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned TAP_COUNT = 4
) (
  input  logic [TAP_COUNT*WIDTH-1:0] i_taps,
  input  logic [WIDTH-1:0]           i_prev,
  output logic [WIDTH-1:0]           o_next
);

  lfsr_word_t w_mask;
  lfsr_word_t w_next;

  always_comb begin
    w_mask = '0;
    for (int unsigned k = 0; k < TAP_COUNT; k++) begin
      w_mask = w_mask | lfsr_tap_mask(lfsr_word_t'(i_taps[k*WIDTH +: WIDTH]), WIDTH);
    end
    w_next = lfsr_next(lfsr_word_t'(i_prev), w_mask, WIDTH);
  end

  assign o_next = WIDTH'(w_next);

endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side checker for the XNOR LFSR generator.
// Predicts each word from the previous received word (self-synchronising),
// acquires lock after LOCK_COUNT consecutive good predictions, then flags and
// counts mismatches; UNLOCK_COUNT consecutive bad words force a re-hunt.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_valid       : i_data carries one LFSR step this cycle
//   i_data        : received LFSR state word
//   i_taps        : TAP_COUNT tap fields, 1-based, 0 = unused
//   i_clear       : clears error counter and sticky flag
//   o_locked      : in LOCKED state
//   o_err         : one-cycle pulse per locked-state mismatch
//   o_err_sticky  : set by any o_err, cleared by i_clear or reset
//   o_err_cnt     : saturating count of locked-state mismatches
//   o_state       : FSM state for debug
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned TAP_COUNT     = 4,
  parameter int unsigned LOCK_COUNT    = 4,
  parameter int unsigned UNLOCK_COUNT  = 3,
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  input  logic [WIDTH-1:0]           i_data,
  input  logic [TAP_COUNT*WIDTH-1:0] i_taps,
  input  logic                       i_clear,
  output logic                       o_locked,
  output logic                       o_err,
  output logic                       o_err_sticky,
  output logic [ERR_CNT_WIDTH-1:0]   o_err_cnt,
  output logic [1:0]                 o_state
);

  localparam int unsigned MatchW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BadW   = $clog2(UNLOCK_COUNT + 1);

  lfsr_chk_state_t          r_state;
  logic [WIDTH-1:0]         r_prev;
  logic [MatchW-1:0]        r_match_cnt;
  logic [BadW-1:0]          r_bad_cnt;
  logic                     r_err;
  logic                     r_sticky;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

  logic [WIDTH-1:0]  w_expected;
  logic              w_all_ones;
  logic              w_match;
  logic              w_err_now;
  logic [MatchW-1:0] w_match_inc;
  logic [BadW-1:0]   w_bad_inc;

  lfsr_predict #(
    .WIDTH     (WIDTH),
    .TAP_COUNT (TAP_COUNT)
  ) u_predict (
    .i_taps (i_taps),
    .i_prev (r_prev),
    .o_next (w_expected)
  );

  // All-ones is the XNOR lockup word: never a valid seed, always a mismatch.
  assign w_all_ones  = &i_data;
  assign w_match     = !w_all_ones && (i_data == w_expected);
  assign w_err_now   = i_valid && (r_state == LOCKED) && !w_match;
  assign w_match_inc = r_match_cnt + MatchW'(1);
  assign w_bad_inc   = r_bad_cnt + BadW'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= HUNT;
      r_prev      <= '0;
      r_match_cnt <= '0;
      r_bad_cnt   <= '0;
      r_err       <= 1'b0;
      r_sticky    <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_err <= w_err_now;

      if (i_valid) begin
        // Always track the received word so the checker resynchronises itself.
        r_prev <= i_data;
        case (r_state)
          HUNT: begin
            if (!w_all_ones) begin
              r_state     <= VERIFY;
              r_match_cnt <= '0;
            end
          end
          VERIFY: begin
            if (w_match) begin
              if (w_match_inc == MatchW'(LOCK_COUNT)) begin
                r_state     <= LOCKED;
                r_match_cnt <= '0;
                r_bad_cnt   <= '0;
              end else begin
                r_match_cnt <= w_match_inc;
              end
            end else begin
              r_match_cnt <= '0;
            end
          end
          LOCKED: begin
            if (w_match) begin
              r_bad_cnt <= '0;
            end else if (w_bad_inc == BadW'(UNLOCK_COUNT)) begin
              r_state   <= HUNT;
              r_bad_cnt <= '0;
            end else begin
              r_bad_cnt <= w_bad_inc;
            end
          end
          default: r_state <= HUNT;
        endcase
      end

      // Clear wins over a same-cycle error; the o_err pulse itself still fires.
      if (i_clear) begin
        r_err_cnt <= '0;
        r_sticky  <= 1'b0;
      end else if (w_err_now) begin
        r_sticky <= 1'b1;
        if (r_err_cnt != '1) begin
          r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
        end
      end
    end
  end

  assign o_locked     = (r_state == LOCKED);
  assign o_err        = r_err;
  assign o_err_sticky = r_sticky;
  assign o_err_cnt    = r_err_cnt;
  assign o_state      = r_state;

endmodule
